// File: rtl/sys_bus_fabric.sv
// Single-master bus fabric: decodes the master request by a 4-bit address tag
// onto NUM_SLV slaves and tracks one outstanding read with timeout and error reporting.
module sys_bus_fabric #(
  parameter int                   NUM_SLV  = 4,
  parameter int                   DATA_W   = 32,
  parameter int                   ADDR_W   = 32,
  parameter logic [4*NUM_SLV-1:0] SLV_TAGS = {4'hA, 4'h9, 4'h8, 4'h0},
  parameter int                   TIMEOUT  = 16,
  parameter logic [DATA_W-1:0]    ERR_DATA = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_en,
  input  logic                      m_rdwr,
  input  logic [DATA_W/8-1:0]       m_mask,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wr_data,
  output logic [DATA_W-1:0]         m_rd_data,
  output logic                      m_rd_valid,
  output logic                      m_busy,
  output logic                      m_err,
  output logic [NUM_SLV-1:0]        s_en,
  output logic                      s_rdwr,
  output logic [DATA_W/8-1:0]       s_mask,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wr_data,
  input  logic [NUM_SLV*DATA_W-1:0] s_rd_data,
  input  logic [NUM_SLV-1:0]        s_ready,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [7:0]                err_cnt
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [DATA_W-1:0]  rd_sel;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Tag decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      hit     = hit | (m_addr[ADDR_W-1 -: 4] == SLV_TAGS[4*i +: 4]);
      hit_idx = (m_addr[ADDR_W-1 -: 4] == SLV_TAGS[4*i +: 4]) ? IDX_W'(i) : hit_idx;
    end
  end

  always_comb begin
    s_en = '0;
    if (m_en && hit && (state_q == S_IDLE)) begin
      s_en[hit_idx] = 1'b1;
    end else begin
      s_en = '0;
    end
  end

  assign s_rdwr     = m_rdwr;
  assign s_mask     = m_mask;
  assign s_addr     = {m_addr[ADDR_W-1:2], 2'b00};
  assign s_wr_data  = m_wr_data;
  assign rd_sel     = s_rd_data[int'(idx_q)*DATA_W +: DATA_W];
  assign m_busy     = (state_q != S_IDLE);
  assign m_rd_data  = rd_data_q;
  assign m_rd_valid = rd_valid_q;
  assign m_err      = err_q;
  assign err_addr   = err_addr_q;
  assign err_cnt    = err_cnt_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (m_en && hit && !m_rdwr) begin
          state_d = S_WAIT;
          idx_d   = hit_idx;
          cnt_d   = '0;
          addr_d  = m_addr;
        end else if (m_en && !hit && m_rdwr) begin
          err_d      = 1'b1;
          err_addr_d = m_addr;
          err_cnt_d  = sat_inc(err_cnt_q);
        end else if (m_en && !hit) begin
          state_d = S_ERR;
          addr_d  = m_addr;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A ready in the expiry cycle still completes normally.
        if (s_ready[idx_q]) begin
          rd_data_d  = rd_sel;
          rd_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        rd_data_d  = ERR_DATA;
        rd_valid_d = 1'b1;
        err_d      = 1'b1;
        err_addr_d = addr_q;
        err_cnt_d  = sat_inc(err_cnt_q);
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_sys_bus_fabric.sv
// Scoreboard bench for sys_bus_fabric: stimulus predicts each completion/error
// into a queue, a negedge monitor pops and compares whenever the fabric responds.
module tb_sys_bus_fabric;

  localparam int          NUM_SLV  = 4;
  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 32;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      m_en, m_rdwr;
  logic [3:0]                m_mask;
  logic [31:0]               m_addr, m_wr_data, m_rd_data;
  logic                      m_rd_valid, m_busy, m_err;
  logic [NUM_SLV-1:0]        s_en, s_ready;
  logic                      s_rdwr;
  logic [3:0]                s_mask;
  logic [31:0]               s_addr, s_wr_data, err_addr;
  logic [NUM_SLV*DATA_W-1:0] s_rd_data;
  logic [7:0]                err_cnt;

  sys_bus_fabric #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                   .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .rst(rst), .m_en(m_en), .m_rdwr(m_rdwr), .m_mask(m_mask),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
    .m_rd_valid(m_rd_valid), .m_busy(m_busy), .m_err(m_err), .s_en(s_en),
    .s_rdwr(s_rdwr), .s_mask(s_mask), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_rd_data(s_rd_data), .s_ready(s_ready), .err_addr(err_addr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        valid;
    logic        err;
    logic [31:0] data;
    logic [31:0] eaddr;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  logic [3:0]  tags [NUM_SLV] = '{4'h0, 4'h8, 4'h9, 4'hA};
  logic [31:0] last_data = 32'h0;
  logic [31:0] mdl_eaddr = 32'h0;
  logic [7:0]  mdl_ecnt = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NUM_SLV; i++) if (a[31:28] == tags[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] rand_tag();
    case ($urandom_range(0, 5))
      0: return 4'h0;
      1: return 4'h8;
      2: return 4'h9;
      3: return 4'hA;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_err(input int c, input logic valid, input logic [31:0] a);
    mdl_ecnt  = (mdl_ecnt == 8'hFF) ? 8'hFF : mdl_ecnt + 8'd1;
    mdl_eaddr = a;
    if (valid) last_data = ERR_DATA;
    sb_q.push_back('{cyc: c, valid: valid, err: 1'b1, data: last_data, eaddr: mdl_eaddr, ecnt: mdl_ecnt});
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] mk);
    int slv;
    logic [3:0] want_en;
    tick();
    m_en = 1'b1; m_rdwr = 1'b1; m_addr = a; m_wr_data = d; m_mask = mk; s_ready = '0;
    #1;
    slv = decode(a);
    want_en = '0;
    if (slv >= 0) want_en[slv] = 1'b1;
    check("wr_s_en", s_en, want_en);
    check("wr_busy", m_busy, 1'b0);
    if (slv >= 0) begin
      check("wr_s_addr", s_addr, {a[31:2], 2'b00});
      check("wr_s_data", {s_rdwr, s_mask, s_wr_data}, {1'b1, mk, d});
    end else begin
      push_err(cyc + 1, 1'b0, a);
    end
  endtask

  // d = cycles after s_en that the slave raises s_ready (0 = never)
  task automatic do_read(input logic [31:0] a, input int d, input logic [31:0] rd, input bit noise);
    int slv, k, vc;
    logic [3:0] want_en, nz;
    tick();
    m_en = 1'b1; m_rdwr = 1'b0; m_addr = a; m_mask = 4'($urandom); s_ready = '0;
    #1;
    k = cyc;
    slv = decode(a);
    want_en = '0;
    if (slv >= 0) want_en[slv] = 1'b1;
    check("rd_s_en", s_en, want_en);
    check("rd_busy_at_issue", m_busy, 1'b0);
    if (slv < 0) begin
      vc = k + 2;
      push_err(vc, 1'b1, a);
    end else if (d == 0 || d > TIMEOUT) begin
      vc = k + TIMEOUT + 2;
      push_err(vc, 1'b1, a);
    end else begin
      vc = k + d + 1;
      last_data = rd;
      sb_q.push_back('{cyc: vc, valid: 1'b1, err: 1'b0, data: rd, eaddr: mdl_eaddr, ecnt: mdl_ecnt});
    end
    for (int j = 1; j < vc - k; j++) begin
      tick();
      m_en      = noise ? 1'($urandom) : 1'b0;
      m_rdwr    = 1'($urandom);
      m_addr    = {rand_tag(), 28'($urandom)};
      s_rd_data = {$urandom, $urandom, $urandom, $urandom};
      nz        = noise ? 4'($urandom) : 4'h0;
      if (slv >= 0) nz[slv] = 1'b0;
      if (slv >= 0 && j == d) begin
        nz[slv] = 1'b1;
        s_rd_data[slv*DATA_W +: DATA_W] = rd;
      end
      s_ready = nz;
      #1;
      check("busy_s_en_blocked", s_en, 4'h0);
      check("busy_high", m_busy, 1'b1);
    end
  endtask

  task automatic idle_cycle();
    tick();
    m_en = 1'b0; s_ready = '0;
    #1;
    check("idle_s_en", s_en, 4'h0);
  endtask

  // Monitor: every response must match the head of the scoreboard in time and content.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        check("resp_missing_cycle", cyc, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
      if (m_rd_valid || m_err) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", {m_rd_valid, m_err}, 2'b00);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_cycle", cyc, mon_e.cyc);
          check("resp_valid_err", {m_rd_valid, m_err}, {mon_e.valid, mon_e.err});
          check("resp_data", m_rd_data, mon_e.data);
          if (mon_e.err) check("err_addr_cnt", {err_addr, err_cnt}, {mon_e.eaddr, mon_e.ecnt});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_en = 1'b0; m_rdwr = 1'b0; m_mask = '0; m_addr = '0; m_wr_data = '0;
    s_ready = '0; s_rd_data = '0;
    tick();
    tick();
    check("reset_outputs", {m_busy, m_rd_valid, m_err, m_rd_data, err_addr, err_cnt}, '0);
    check("reset_s_en", s_en, 4'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    do_write(32'h0000_0010, 32'h1234_5678, 4'hF);
    idle_cycle();
    do_read(32'h9000_0004, 3, 32'hCAFE_0001, 1'b0);
    do_read(32'h8000_0000, 0, 32'h0, 1'b0);
    do_read(32'hF000_0000, 1, 32'h0, 1'b0);
    do_write(32'hF000_0000, 32'h5555_AAAA, 4'h3);
    idle_cycle();
    do_read(32'hA000_0008, 4, 32'h0BAD_F00D, 1'b1);
    do_read(32'h8000_0100, TIMEOUT, 32'h7777_1234, 1'b1);
    do_read(32'h0000_0200, TIMEOUT + 1, 32'h1111_2222, 1'b0);
    do_read(32'h9000_0300, 1, 32'h3333_4444, 1'b1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_write({rand_tag(), 28'($urandom)}, $urandom, 4'($urandom));
      else
        do_read({rand_tag(), 28'($urandom)}, $urandom_range(0, TIMEOUT + 2), $urandom, 1'($urandom));
    end

    // Reset while a read is outstanding abandons it.
    tick();
    m_en = 1'b1; m_rdwr = 1'b0; m_addr = 32'h0000_0100; s_ready = '0;
    tick();
    m_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midwait_reset", {m_busy, m_rd_valid, m_err, m_rd_data, err_addr, err_cnt}, '0);
    last_data = 32'h0; mdl_eaddr = 32'h0; mdl_ecnt = 8'd0;
    do_read(32'hA000_0000, 2, 32'h600D_0001, 1'b0);

    for (int n = 0; n < 300; n++)
      do_write({4'hF, 28'($urandom)}, $urandom, 4'hF);

    for (int n = 0; n < 40; n++) begin
      tick();
      m_en = 1'b0; s_ready = '0;
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) break;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    check("err_cnt_saturated", err_cnt, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sys_bus_fabric.md
Name: sys_bus_fabric

Overview:
- Parametrised single-master system-bus fabric that replaces hard-coded top-level address decode and read-data muxing.
- Decodes the master request onto NUM_SLV slaves by a 4-bit address tag and tracks the outstanding read.
- Supports variable-latency slaves, with a timeout watchdog and an error path for unmapped addresses.
- Sits between the pipelined core's data bus and the memory, GEMM configuration, UART and future peripherals.

Parameters:
- NUM_SLV, 4, number of slave ports.
- DATA_W, 32, data width; mask width is DATA_W/8.
- ADDR_W, 32, address width.
- SLV_TAGS, {4'hA,4'h9,4'h8,4'h0}, packed 4*NUM_SLV bits; slave i decodes when addr[ADDR_W-1:ADDR_W-4] == SLV_TAGS[4i+3:4i].
- TIMEOUT, 16, cycles waited for s_ready before a read is declared failed (minimum 2).
- ERR_DATA, 32'hDEADBEEF, read data returned on error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_en  in  1  master request
- m_rdwr  in  1  1=write, 0=read
- m_mask  in  DATA_W/8  byte enables
- m_addr  in  ADDR_W  byte address
- m_wr_data  in  DATA_W  write data
- m_rd_data  out  DATA_W  read data, valid while m_rd_valid
- m_rd_valid  out  1  read completion pulse
- m_busy  out  1  read outstanding; master must hold off
- m_err  out  1  error pulse
- s_en  out  NUM_SLV  one-hot slave select
- s_rdwr  out  1  passthrough of m_rdwr
- s_mask  out  DATA_W/8  passthrough of m_mask
- s_addr  out  ADDR_W  {m_addr[ADDR_W-1:2],2'b00}
- s_wr_data  out  DATA_W  passthrough of m_wr_data
- s_rd_data  in  NUM_SLV*DATA_W  slave read data, slave i at [DATA_W*i +: DATA_W]
- s_ready  in  NUM_SLV  slave read-data-valid
- err_addr  out  ADDR_W  address of the last errored access (sticky)
- err_cnt  out  8  saturating error counter

Behaviour:
- Reset: state=IDLE. m_rd_data=0, m_rd_valid=0, m_busy=0, m_err=0, err_addr=0, err_cnt=0, timeout counter=0.
- Decode: a slave hits when its tag matches. With multiple matches, the lowest index wins. No match means unmapped.
- s_en[i] = m_en & hit_i & (state==IDLE), combinational.
- Requests presented while state≠IDLE are ignored and not forwarded.
- States:
  - IDLE:
    - Mapped write: s_en pulses for one cycle; the write is posted; stay in IDLE; no busy.
    - Mapped read: s_en pulses; capture the slave index; clear the timeout counter; go to WAIT.
    - Unmapped read: go to ERR.
    - Unmapped write: dropped, s_en stays 0; m_err pulses next cycle; err_addr and err_cnt update; stay in IDLE.
  - WAIT:
    - m_busy=1. s_ready is sampled only for the captured index, and only from the cycle after s_en.
    - On s_ready[idx]: m_rd_data <= s_rd_data[idx]; m_rd_valid=1 the next cycle; go to IDLE.
    - Otherwise the counter increments. At TIMEOUT-1 go to ERR.
    - If s_ready arrives in the same cycle as timeout expiry, s_ready wins: normal completion, no error.
  - ERR (one cycle):
    - m_rd_data <= ERR_DATA; m_rd_valid=1 and m_err=1 the next cycle.
    - err_addr <= the failing address; err_cnt += 1, saturating at 255; go to IDLE.
- Latency:
  - A zero-wait slave (s_ready the cycle after s_en) gives m_rd_valid 2 cycles after the request.
  - An unmapped read gives m_rd_valid 2 cycles after the request.
  - m_busy is high from the cycle after issue through the cycle before m_rd_valid. It is low in the m_rd_valid cycle, so a new request may issue in that same cycle.
- m_rd_valid and m_err are single-cycle pulses.
- m_rd_data holds its last value between reads.
- s_ready on a non-captured slave, or while in IDLE, is ignored.
- Reset mid-WAIT: the outstanding read is abandoned; no rd_valid or err; all outputs return to reset values; the counter is cleared.
- Internal registers hold the failing address and the slave index.

Test Plan:
- Write 32'h1234_5678 to 0x0000_0010, mask 4'hF → s_en=4'b0001 for one cycle; s_addr=0x10; m_busy stays 0.
- Read 0x9000_0004 with slave 2 asserting s_ready 3 cycles after s_en and data 32'hCAFE_0001 → m_busy high 3 cycles; m_rd_valid pulses once with 32'hCAFE_0001; m_err=0.
- Read 0x8000_0000 with s_ready tied 0 → after TIMEOUT cycles, m_rd_valid=1, m_rd_data=32'hDEADBEEF, m_err=1, err_addr=0x8000_0000, err_cnt=1.
- Read 0xF000_0000 (unmapped) → s_en=0; 2 cycles later m_rd_valid=1 with ERR_DATA; err_cnt increments. Write to 0xF000_0000 → m_err pulse, no rd_valid.
- New request issued during m_busy, plus s_ready on another slave → no s_en asserted, completion unaffected. s_ready coincident with the timeout-expiry cycle → normal data, m_err=0.
- Assert rst during WAIT → all outputs 0 next cycle; a subsequent read completes normally. Then 300 unmapped writes → err_cnt saturates at 255.
